// File: rtl/bus_master_if.sv
// Controller, slave and arbiter signals seen by the serial-bus master.
interface bus_master_if #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 16
);
  logic                     burst;
  logic                     rdWr;
  logic                     inEx;
  logic [DATA_WIDTH-1:0]    data;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [1:0]               slaveId;
  logic                     start;
  logic                     doneCom;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic                     rD;
  logic                     ready;
  logic                     control;
  logic                     wrD;
  logic                     valid;
  logic                     last;
  logic                     arbCont;
  logic                     arbSend;

  modport master (
    input  burst, rdWr, inEx, data, address, slaveId, start, rD, ready, arbCont,
    output doneCom, dataOut, control, wrD, valid, last, arbSend
  );

  modport slave (
    output burst, rdWr, inEx, data, address, slaveId, start, rD, ready, arbCont,
    input  doneCom, dataOut, control, wrD, valid, last, arbSend
  );
endinterface

// File: rtl/bus_master.sv
// Serial-bus master: three-pulse configuration, bus request, 17-bit control
// frame, then bit-serial data transfer to or from a local word buffer.
module bus_master #(
  parameter int unsigned MEMORY_DEPTH = 4096,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BURST_LEN    = 4
) (
  input logic          clk,
  input logic          rstN,
  bus_master_if.master bus
);
  localparam int unsigned ADDRESS_WIDTH = $clog2(MEMORY_DEPTH);
  localparam int unsigned FRAME_LEN     = 5 + ADDRESS_WIDTH;
  localparam int unsigned FRM_W         = $clog2(FRAME_LEN);
  localparam int unsigned BIT_W         = $clog2(DATA_WIDTH);
  localparam int unsigned WRD_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, CONFIG, CONFIG_END, REQ, CTRL, WRITE, READ, DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               slave_q, slave_d;
  logic                     rdwr_q, rdwr_d;
  logic                     burst_q, burst_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [FRAME_LEN-1:0]     frame_q, frame_d;
  logic [FRM_W-1:0]         frm_cnt_q, frm_cnt_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WRD_W-1:0]         word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]    dataout_q, dataout_d;

  logic                     load_word;
  logic [ADDRESS_WIDTH-1:0] load_addr;
  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic                     final_word;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     control_o, wrd_o, valid_o, last_o, arbsend_o, donecom_o;

  logic [DATA_WIDTH-1:0]    mem_q [MEMORY_DEPTH];

  assign word_addr  = addr_q + ADDRESS_WIDTH'(word_cnt_q);
  assign final_word = !burst_q || (word_cnt_q == WRD_W'(BURST_LEN - 1));

  // Next-state, counters, buffer write port and bus outputs.
  always_comb begin
    state_d    = state_q;
    slave_d    = slave_q;
    rdwr_d     = rdwr_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    frame_d    = frame_q;
    frm_cnt_d  = frm_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    dataout_d  = dataout_q;
    load_word  = 1'b0;
    load_addr  = word_addr;
    mem_we     = 1'b0;
    mem_waddr  = word_addr;
    mem_wdata  = {shreg_q[DATA_WIDTH-2:0], bus.rD};
    control_o  = 1'b0;
    wrd_o      = 1'b0;
    valid_o    = 1'b0;
    last_o     = 1'b0;
    arbsend_o  = 1'b0;
    donecom_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CONFIG;
          slave_d = bus.slaveId;
          rdwr_d  = bus.rdWr;
          burst_d = bus.burst;
          addr_d  = bus.address;
          if (bus.inEx) begin
            mem_we    = 1'b1;
            mem_waddr = bus.address;
            mem_wdata = bus.data;
          end
        end
      end
      CONFIG:     if (bus.start) state_d = CONFIG_END;
      CONFIG_END: if (bus.start) state_d = REQ;
      REQ: begin
        arbsend_o = 1'b1;
        if (bus.arbCont) begin
          state_d    = CTRL;
          frame_d    = {1'b1, slave_q, rdwr_q, burst_q, addr_q};
          frm_cnt_d  = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      CTRL: begin
        arbsend_o = 1'b1;
        control_o = frame_q[FRAME_LEN-1];
        if (!bus.arbCont) begin
          state_d = REQ;
        end else if (frm_cnt_q == FRM_W'(FRAME_LEN - 1)) begin
          state_d   = rdwr_q ? WRITE : READ;
          load_word = rdwr_q;
          load_addr = addr_q;
        end else begin
          frame_d   = {frame_q[FRAME_LEN-2:0], 1'b0};
          frm_cnt_d = frm_cnt_q + FRM_W'(1);
        end
      end
      WRITE: begin
        arbsend_o = 1'b1;
        wrd_o     = shreg_q[DATA_WIDTH-1];
        valid_o   = bus.ready;
        last_o    = final_word && (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
        if (!bus.arbCont) begin
          state_d = REQ;
        end else if (bus.ready) begin
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (final_word) begin
              state_d = DONE;
            end else begin
              word_cnt_d = word_cnt_q + WRD_W'(1);
              load_word  = 1'b1;
              load_addr  = word_addr + ADDRESS_WIDTH'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      READ: begin
        arbsend_o = 1'b1;
        if (!bus.arbCont) begin
          state_d = REQ;
        end else if (bus.ready) begin
          shreg_d = mem_wdata;
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            mem_we    = 1'b1;
            dataout_d = mem_wdata;
            if (final_word) state_d = DONE;
            else            word_cnt_d = word_cnt_q + WRD_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      DONE: begin
        donecom_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; the shifter loads straight from the buffer
  // when a new write word begins, so the first bit is ready in that cycle.
  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      state_q    <= IDLE;
      slave_q    <= '0;
      rdwr_q     <= 1'b0;
      burst_q    <= 1'b0;
      addr_q     <= '0;
      frame_q    <= '0;
      frm_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      dataout_q  <= '0;
    end else begin
      state_q    <= state_d;
      slave_q    <= slave_d;
      rdwr_q     <= rdwr_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      frame_q    <= frame_d;
      frm_cnt_q  <= frm_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= load_word ? mem_q[load_addr] : shreg_d;
      dataout_q  <= dataout_d;
    end
  end

  // Buffer write port; contents survive reset, but no writes land during it.
  always_ff @(posedge clk) begin
    if (mem_we && !rstN) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.control = control_o;
  assign bus.wrD     = wrd_o;
  assign bus.valid   = valid_o;
  assign bus.last    = last_o;
  assign bus.arbSend = arbsend_o;
  assign bus.doneCom = donecom_o;
  assign bus.dataOut = dataout_q;
endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: expected serial bits and read words are
// queued when stimulus is set up and popped as the DUT produces them.
module tb_bus_master;
  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit          exp_wr[$];
  bit          rd_src[$];
  logic [15:0] exp_word[$];

  bus_master_if #(.ADDRESS_WIDTH(12), .DATA_WIDTH(16)) bif ();

  bus_master #(.MEMORY_DEPTH(4096), .DATA_WIDTH(16), .BURST_LEN(4)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] outs();
    return {bif.arbSend, bif.control, bif.wrD, bif.valid, bif.last, bif.doneCom, bif.dataOut};
  endfunction

  function automatic logic [16:0] mkframe(input logic [1:0] sid, input logic rw,
                                          input logic bst, input logic [11:0] adr);
    return {1'b1, sid, rw, bst, adr};
  endfunction

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) exp_wr.push_back(w[i]);
  endtask

  task automatic push_rd(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) rd_src.push_back(w[i]);
    exp_word.push_back(w);
  endtask

  // Three start pulses; returns during the first REQ cycle with inputs scrambled.
  task automatic start_seq(input logic [1:0] sid, input logic rw, input logic bst,
                           input logic [11:0] adr, input logic ie, input logic [15:0] d);
    @(posedge clk); #1;
    bif.slaveId = sid; bif.rdWr = rw; bif.burst = bst;
    bif.address = adr; bif.inEx = ie; bif.data = d;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
    end
    bif.slaveId = ~sid; bif.rdWr = ~rw; bif.burst = ~bst;
    bif.address = ~adr; bif.inEx = ~ie; bif.data = ~d;
  endtask

  // Grant, control frame (optionally dropping the grant once), data phase, DONE.
  task automatic run_xfer(input string tag, input logic [16:0] frm, input bit rw,
                          input int grant_delay, input int drop_at, input bit toggle);
    int cyc = 0;
    int rbits = 0;
    int b = 0;
    bit rdy;
    bit pend = 1'b0;
    bit dropped = 1'b0;
    bit e;
    logic [15:0] ew;
    bif.arbCont = 1'b0;
    bif.ready   = 1'b0;
    for (int i = 0; i <= grant_delay; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bif.arbSend, bif.control, bif.valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s req: arbSend,control,valid=%b expected 100", tag,
                 {bif.arbSend, bif.control, bif.valid});
      end
      if (i == grant_delay) bif.arbCont = 1'b1;
      @(posedge clk); #1;
    end
    while (b < 17) begin
      @(negedge clk);
      n_checks++;
      if ({bif.control, bif.arbSend} !== {frm[16-b], 1'b1}) begin
        n_fail++;
        $display("FAIL %s ctrl bit %0d: control,arbSend=%b expected %b", tag, b,
                 {bif.control, bif.arbSend}, {frm[16-b], 1'b1});
      end
      if (!dropped && b == drop_at) begin
        dropped = 1'b1;
        bif.arbCont = 1'b0;
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
          @(negedge clk);
          n_checks++;
          if ({bif.arbSend, bif.control} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s regrant wait: arbSend,control=%b expected 10", tag,
                     {bif.arbSend, bif.control});
          end
          if (r == 1) bif.arbCont = 1'b1;
          @(posedge clk); #1;
        end
        b = 0;
      end else begin
        @(posedge clk); #1;
        b++;
      end
    end
    while ((rw ? exp_wr.size() : rd_src.size()) > 0 && cyc < 2000) begin
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      bif.ready = rdy;
      bif.rD = (!rw && rdy) ? rd_src[0] : 1'($urandom);
      @(negedge clk);
      if (rw) begin
        n_checks++;
        if (bif.valid !== rdy) begin
          n_fail++;
          $display("FAIL %s valid cyc %0d: got %b expected %b", tag, cyc, bif.valid, rdy);
        end
        if (rdy) begin
          e = exp_wr.pop_front();
          n_checks++;
          if ({bif.wrD, bif.last} !== {e, exp_wr.size() == 0}) begin
            n_fail++;
            $display("FAIL %s wrD,last cyc %0d: got %b expected %b", tag, cyc,
                     {bif.wrD, bif.last}, {e, exp_wr.size() == 0});
          end
        end else begin
          n_checks++;
          if (bif.wrD !== exp_wr[0]) begin
            n_fail++;
            $display("FAIL %s wrD hold cyc %0d: got %b expected %b", tag, cyc, bif.wrD, exp_wr[0]);
          end
        end
      end else begin
        if (pend) begin
          ew = exp_word.pop_front();
          pend = 1'b0;
          n_checks++;
          if (bif.dataOut !== ew) begin
            n_fail++;
            $display("FAIL %s dataOut: got %h expected %h", tag, bif.dataOut, ew);
          end
        end
        n_checks++;
        if ({bif.valid, bif.wrD, bif.last, bif.control} !== 4'b0000) begin
          n_fail++;
          $display("FAIL %s read idle outs: got %b expected 0000", tag,
                   {bif.valid, bif.wrD, bif.last, bif.control});
        end
        if (rdy) begin
          void'(rd_src.pop_front());
          rbits++;
          if (rbits % 16 == 0) pend = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc >= 2000) begin
      n_fail++;
      $display("FAIL %s data timeout: cycles %0d expected < 2000", tag, cyc);
    end
    bif.ready = 1'b0;
    @(negedge clk);
    if (pend) begin
      ew = exp_word.pop_front();
      n_checks++;
      if (bif.dataOut !== ew) begin
        n_fail++;
        $display("FAIL %s dataOut last: got %h expected %h", tag, bif.dataOut, ew);
      end
    end
    n_checks++;
    if ({bif.doneCom, bif.arbSend, bif.valid, bif.last, bif.control} !== 5'b10000) begin
      n_fail++;
      $display("FAIL %s done: doneCom,arbSend,valid,last,control=%b expected 10000", tag,
               {bif.doneCom, bif.arbSend, bif.valid, bif.last, bif.control});
    end
    bif.arbCont = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bif.doneCom, bif.arbSend} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s after done: doneCom,arbSend=%b expected 00", tag, {bif.doneCom, bif.arbSend});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bif.start = (i % 2 == 0); bif.inEx = 1'b1; bif.address = 12'd13; bif.data = 16'hDEAD;
      @(negedge clk);
      n_checks++;
      if (outs() !== '0) begin
        n_fail++;
        $display("FAIL reset hold cyc %0d: outputs=%h expected 0", i, outs());
      end
    end
    @(posedge clk); #1;
    bif.start = 1'b0;
    rstN = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== '0) begin
        n_fail++;
        $display("FAIL reset release: outputs=%h expected 0", outs());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_write();
    start_seq(2'b01, 1'b1, 1'b0, 12'd13, 1'b1, 16'hA5C3);
    push_word(16'hA5C3);
    run_xfer("single_write", mkframe(2'b01, 1'b1, 1'b0, 12'd13), 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_single_read();
    start_seq(2'b10, 1'b0, 1'b0, 12'd13, 1'b0, 16'h0000);
    push_rd(16'h1234);
    run_xfer("single_read", mkframe(2'b10, 1'b0, 1'b0, 12'd13), 1'b0, 0, -1, 1'b0);
    start_seq(2'b01, 1'b1, 1'b0, 12'd13, 1'b0, 16'hFFFF);
    push_word(16'h1234);
    run_xfer("read_buffer", mkframe(2'b01, 1'b1, 1'b0, 12'd13), 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_burst_write();
    logic [15:0] w [4];
    w[0] = 16'hC0DE; w[1] = 16'hBEEF; w[2] = 16'h0F0F; w[3] = 16'h8001;
    start_seq(2'b00, 1'b0, 1'b1, 12'd13, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) push_rd(w[i]);
    run_xfer("burst_fill", mkframe(2'b00, 1'b0, 1'b1, 12'd13), 1'b0, 2, -1, 1'b0);
    start_seq(2'b11, 1'b1, 1'b1, 12'd13, 1'b0, 16'h7777);
    for (int i = 0; i < 4; i++) push_word(w[i]);
    run_xfer("burst_write", mkframe(2'b11, 1'b1, 1'b1, 12'd13), 1'b1, 1, -1, 1'b1);
  endtask

  task automatic test_arbitration();
    start_seq(2'b11, 1'b1, 1'b0, 12'd100, 1'b1, 16'h3C96);
    push_word(16'h3C96);
    run_xfer("arbitration", mkframe(2'b11, 1'b1, 1'b0, 12'd100), 1'b1, 10, 6, 1'b0);
  endtask

  task automatic test_addr_wrap();
    logic [15:0] x [4];
    for (int i = 0; i < 4; i++) x[i] = 16'($urandom);
    start_seq(2'b10, 1'b0, 1'b1, 12'd4094, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) push_rd(x[i]);
    run_xfer("wrap_fill", mkframe(2'b10, 1'b0, 1'b1, 12'd4094), 1'b0, 0, -1, 1'b0);
    start_seq(2'b01, 1'b1, 1'b1, 12'd4094, 1'b1, 16'h5AA5);
    push_word(16'h5AA5);
    for (int i = 1; i < 4; i++) push_word(x[i]);
    run_xfer("wrap_write", mkframe(2'b01, 1'b1, 1'b1, 12'd4094), 1'b1, 0, -1, 1'b0);
    start_seq(2'b00, 1'b1, 1'b0, 12'd0, 1'b0, 16'h0000);
    push_word(x[2]);
    run_xfer("wrap_addr0", mkframe(2'b00, 1'b1, 1'b0, 12'd0), 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_seq(2'b00, 1'b1, 1'b1, 12'd13, 1'b0, 16'h0000);
    bif.arbCont = 1'b1;
    bif.ready   = 1'b1;
    repeat (25) @(posedge clk);
    #3 rstN = 1'b1;
    #1;
    n_checks++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid async: outputs=%h expected 0", outs());
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstN = 1'b0;
    bif.arbCont = 1'b0;
    bif.ready   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid idle: outputs=%h expected 0", outs());
    end
    start_seq(2'b01, 1'b1, 1'b0, 12'd13, 1'b0, 16'h0000);
    push_word(16'hC0DE);
    run_xfer("reset_mid_buffer", mkframe(2'b01, 1'b1, 1'b0, 12'd13), 1'b1, 0, -1, 1'b0);
  endtask

  initial begin
    bif.burst = 1'b0; bif.rdWr = 1'b0; bif.inEx = 1'b0; bif.data = '0;
    bif.address = '0; bif.slaveId = '0; bif.start = 1'b0;
    bif.rD = 1'b0; bif.ready = 1'b0; bif.arbCont = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_arbitration();
    test_addr_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
